// File: rtl/sar_search_controller.sv
// Successive-approximation search controller driving an unsigned comparator.
// Walks the trial bit MSB-first, exits early on equality, then verifies.
module sar_search_controller #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] guess_o,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    TRIAL,
    VERIFY,
    DONE
  } state_t;

  state_t           state;
  logic [3:0]       settleCnt;
  logic [IW-1:0]    bitIdx;
  logic [WIDTH-1:0] acc;

  logic             legal;
  logic             sampleNow;
  logic [IW-1:0]    nextIdx;
  logic [WIDTH-1:0] nextAcc;
  logic [WIDTH-1:0] trialBit;

  always_comb begin
    legal     = 1'b0;
    unique case ({cmp_gt, cmp_lt, cmp_eq})
      3'b100, 3'b010, 3'b001: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
    sampleNow = (settleCnt == 4'(SETTLE));
    nextIdx   = bitIdx - 1'b1;
    // lt keeps the trial bit, gt drops it
    nextAcc   = cmp_lt ? guess_o : acc;
    trialBit  = WIDTH'(1) << nextIdx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      settleCnt <= '0;
      bitIdx    <= '0;
      acc       <= '0;
      guess_o   <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            acc       <= '0;
            bitIdx    <= IW'(WIDTH - 1);
            guess_o   <= MSB;
            settleCnt <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            found     <= 1'b0;
            err       <= 1'b0;
            state     <= TRIAL;
          end
        end
        TRIAL: begin
          if (!sampleNow) begin
            settleCnt <= settleCnt + 4'd1;
          end else begin
            settleCnt <= '0;
            if (!legal) begin
              result <= guess_o;
              err    <= 1'b1;
              found  <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else if (cmp_eq) begin
              result <= guess_o;
              found  <= 1'b1;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              acc <= nextAcc;
              if (bitIdx != '0) begin
                bitIdx  <= nextIdx;
                guess_o <= nextAcc | trialBit;
              end else begin
                guess_o <= nextAcc;
                state   <= VERIFY;
              end
            end
          end
        end
        VERIFY: begin
          if (!sampleNow) begin
            settleCnt <= settleCnt + 4'd1;
          end else begin
            settleCnt <= '0;
            result    <= acc;
            guess_o   <= acc;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
            if (legal && cmp_eq) begin
              found <= 1'b1;
              err   <= 1'b0;
            end else begin
              found <= 1'b0;
              err   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_controller.sv
// Bench for sar_search_controller: random targets checked against an
// arithmetic model of the MSB-first search (default and SETTLE=2 builds).
module tb_sar_search_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start2;
  logic       gt1, lt1, eq1, bad1;
  logic       gt2, lt2, eq2;
  logic [3:0] target1, target2;
  logic [3:0] guess1, result1, guess2, result2;
  logic       busy1, done1, found1, err1;
  logic       busy2, done2, found2, err2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    gt1 = guess1 > target1;
    lt1 = guess1 < target1;
    eq1 = guess1 == target1;
    if (bad1) begin
      gt1 = 1'b1;
      lt1 = 1'b1;
      eq1 = 1'b0;
    end
  end

  sar_search_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .cmp_gt(gt1), .cmp_lt(lt1), .cmp_eq(eq1),
    .guess_o(guess1), .result(result1), .busy(busy1),
    .done(done1), .found(found1), .err(err1)
  );

  sar_search_controller #(.WIDTH(4), .SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .cmp_gt(gt2), .cmp_lt(lt2), .cmp_eq(eq2),
    .guess_o(guess2), .result(result2), .busy(busy2),
    .done(done2), .found(found2), .err(err2)
  );

  // Number of samples: trial j hits eq when the target's lowest set bit
  // is bit 3-j; a zero target needs all four trials plus the verify.
  function automatic int expLen(input int t);
    for (int b = 0; b < 4; b++)
      if (t[b]) return 4 - b;
    return 5;
  endfunction

  // Trial j keeps the target's bits above bit 3-j and sets bit 3-j.
  function automatic logic [3:0] expGuess(input int t, input int j);
    int lowMask;
    if (j >= 4) return t[3:0];
    lowMask = (1 << (4 - j)) - 1;
    return 4'((t & ~lowMask) | (1 << (3 - j)));
  endfunction

  task automatic test_reset();
    checks++; if ({guess1, result1, busy1, done1, found1, err1} !== 12'd0) begin errors++; $display("FAIL reset1: got %h want 0", {guess1, result1, busy1, done1, found1, err1}); end
    checks++; if ({guess2, result2, busy2, done2, found2, err2} !== 12'd0) begin errors++; $display("FAIL reset2: got %h want 0", {guess2, result2, busy2, done2, found2, err2}); end
  endtask

  task automatic test_search(input int t, input bit midStart);
    int len;
    int k;
    len = expLen(t);
    target1 = t[3:0];
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL start t=%0d: done=%0b busy=%0b want 0 1", t, done1, busy1); end
    k = 1;
    while (k <= 20) begin
      if (k <= len) begin
        checks++; if (guess1 !== expGuess(t, k - 1)) begin errors++; $display("FAIL guess t=%0d trial=%0d: got %0d want %0d", t, k - 1, guess1, expGuess(t, k - 1)); end
      end
      start1 = midStart && (k == 1);
      @(posedge clk); #1;
      start1 = 1'b0;
      if (done1) break;
      k++;
    end
    checks++; if (k !== len) begin errors++; $display("FAIL latency t=%0d: got %0d want %0d", t, k, len); end
    checks++; if (result1 !== t[3:0] || guess1 !== t[3:0]) begin errors++; $display("FAIL result t=%0d: got %0d/%0d want %0d", t, result1, guess1, t); end
    checks++; if (found1 !== 1'b1 || err1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL status t=%0d: found=%0b err=%0b busy=%0b want 1 0 0", t, found1, err1, busy1); end
    @(posedge clk); #1;
    checks++; if (done1 !== 1'b1 || result1 !== t[3:0]) begin errors++; $display("FAIL hold t=%0d: done=%0b result=%0d want 1 %0d", t, done1, result1, t); end
  endtask

  task automatic test_illegal();
    target1 = 4'd11;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    bad1 = 1'b1;
    @(posedge clk); #1;
    bad1 = 1'b0;
    checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL illegal done: done=%0b busy=%0b want 1 0", done1, busy1); end
    checks++; if (err1 !== 1'b1 || found1 !== 1'b0 || result1 !== 4'd12) begin errors++; $display("FAIL illegal status: err=%0b found=%0b result=%0d want 1 0 12", err1, found1, result1); end
  endtask

  task automatic test_midreset();
    int t;
    t = $urandom_range(0, 7) * 2 + 1;
    target1 = t[3:0];
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (guess1 !== expGuess(t, 2) || busy1 !== 1'b1) begin errors++; $display("FAIL third trial t=%0d: guess=%0d busy=%0b want %0d 1", t, guess1, busy1, expGuess(t, 2)); end
    rst_n = 1'b0;
    #1;
    checks++; if ({guess1, result1, busy1, done1, found1, err1} !== 12'd0) begin errors++; $display("FAIL midreset: got %h want 0", {guess1, result1, busy1, done1, found1, err1}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL idle after reset: busy=%0b done=%0b want 0 0", busy1, done1); end
  endtask

  task automatic test_settle(input int t);
    int len;
    int k;
    logic [2:0] fl;
    len = expLen(t);
    target2 = t[3:0];
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    k = 1;
    while (k <= 60) begin
      if (k % 3 == 0) begin
        gt2 = guess2 > target2;
        lt2 = guess2 < target2;
        eq2 = guess2 == target2;
      end else begin
        fl = 3'($urandom);
        {gt2, lt2, eq2} = fl;
      end
      if ((k - 1) / 3 < len) begin
        checks++; if (guess2 !== expGuess(t, (k - 1) / 3)) begin errors++; $display("FAIL settle guess t=%0d cyc=%0d: got %0d want %0d", t, k, guess2, expGuess(t, (k - 1) / 3)); end
      end
      @(posedge clk); #1;
      if (done2) break;
      k++;
    end
    {gt2, lt2, eq2} = 3'b000;
    checks++; if (k !== 3 * len) begin errors++; $display("FAIL settle latency t=%0d: got %0d want %0d", t, k, 3 * len); end
    checks++; if (result2 !== t[3:0] || found2 !== 1'b1 || err2 !== 1'b0) begin errors++; $display("FAIL settle result t=%0d: got %0d f=%0b e=%0b want %0d 1 0", t, result2, found2, err2, t); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++)
      test_search($urandom_range(0, 15), i[0]);
  endtask

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    bad1 = 1'b0;
    target1 = 4'd0;
    target2 = 4'd0;
    {gt2, lt2, eq2} = 3'b000;
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_search(11, 1'b0);
    test_search(0, 1'b0);
    test_search(15, 1'b0);
    test_search(7, 1'b1);
    test_illegal();
    test_search(8, 1'b0);
    test_back_to_back();
    test_midreset();
    test_settle(0);
    for (int i = 0; i < 3; i++)
      test_settle($urandom_range(0, 15));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
